// File: rtl/mipi_tx_pkg.sv
// Shared definitions for the DSI HS burst scheduler: FSM encoding,
// transmitter timing constants and lane-mux select values.
package mipi_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_BURST = 3'd2,
    ST_TAIL  = 3'd3,
    ST_GAP   = 3'd4
  } sched_state_e;

  // Transmitter data pipeline depth and LP-11 end-sequence timing at its defaults.
  localparam int HS_DATA_S   = 72;
  localparam int LP_11_CLK_E = 102;

  localparam logic SEL_VID = 1'b0;
  localparam logic SEL_CMD = 1'b1;

endpackage

// File: rtl/mipi_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer names the requester that
// wins a tie and moves to the other requester whenever a grant is taken.
module mipi_rr_arb2
  import mipi_tx_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req_vid,
  input  logic i_req_cmd,
  output logic o_gnt_vid,
  output logic o_gnt_cmd
);

  logic r_ptr;
  logic w_gnt_vid;
  logic w_gnt_cmd;

  always_comb begin
    w_gnt_vid = 1'b0;
    w_gnt_cmd = 1'b0;
    if (i_en) begin
      if (i_req_vid && i_req_cmd) begin
        w_gnt_cmd = (r_ptr == SEL_CMD);
        w_gnt_vid = (r_ptr == SEL_VID);
      end else begin
        w_gnt_vid = i_req_vid;
        w_gnt_cmd = i_req_cmd;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= SEL_VID;
    end else if (w_gnt_vid) begin
      r_ptr <= SEL_CMD;
    end else if (w_gnt_cmd) begin
      r_ptr <= SEL_VID;
    end
  end

  assign o_gnt_vid = w_gnt_vid;
  assign o_gnt_cmd = w_gnt_cmd;

endmodule

// File: rtl/mipi_hs_burst_sched.sv
// HS burst sequencer for the DSI lane transmitter: arbitrates video and command
// builders, opens the HS window, aligns read strobes and enforces the LP-11 gap.
module mipi_hs_burst_sched
  import mipi_tx_pkg::*;
#(
  parameter int LEN_W        = 16,
  parameter int HS_RD_OFS    = 0,
  parameter int HS_TRAIL_PAD = HS_DATA_S,
  parameter int MIN_LP_GAP   = 96
) (
  input  logic             I_lcd_clk,
  input  logic             I_rst_n,
  input  logic             I_init_done,
  input  logic             I_vid_req,
  input  logic [LEN_W-1:0] I_vid_len,
  output logic             O_vid_ack,
  output logic             O_vid_rd,
  input  logic             I_cmd_req,
  input  logic [LEN_W-1:0] I_cmd_len,
  output logic             O_cmd_ack,
  output logic             O_cmd_rd,
  output logic             O_sel,
  output logic             O_hs_en,
  output logic             O_busy,
  output logic [2:0]       O_dbg_state
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(HS_RD_OFS);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(HS_TRAIL_PAD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(MIN_LP_GAP - 1);

  sched_state_e     r_state;
  logic [LEN_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vid_ack;
  logic             r_cmd_ack;
  logic             r_vid_rd;
  logic             r_cmd_rd;
  logic             r_sel;
  logic             r_hs_en;
  logic             r_busy;

  logic             w_arb_en;
  logic             w_gnt_vid;
  logic             w_gnt_cmd;
  logic [LEN_W-1:0] w_len;

  // An ack still showing means the requester has not yet seen it and may still
  // be holding its request, so no new grant is taken in that cycle.
  assign w_arb_en = (r_state == ST_IDLE) && I_init_done && !r_vid_ack && !r_cmd_ack;
  assign w_len    = w_gnt_cmd ? I_cmd_len : I_vid_len;

  mipi_rr_arb2 u_arb (
    .i_clk     (I_lcd_clk),
    .i_rst_n   (I_rst_n),
    .i_en      (w_arb_en),
    .i_req_vid (I_vid_req),
    .i_req_cmd (I_cmd_req),
    .o_gnt_vid (w_gnt_vid),
    .o_gnt_cmd (w_gnt_cmd)
  );

  always_ff @(posedge I_lcd_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_vid_ack <= 1'b0;
      r_cmd_ack <= 1'b0;
      r_vid_rd  <= 1'b0;
      r_cmd_rd  <= 1'b0;
      r_sel     <= SEL_VID;
      r_hs_en   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_vid_ack <= 1'b0;
      r_cmd_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vid || w_gnt_cmd) begin
            r_vid_ack <= w_gnt_vid;
            r_cmd_ack <= w_gnt_cmd;
            r_sel     <= w_gnt_cmd ? SEL_CMD : SEL_VID;
            r_rem     <= w_len;
            r_cnt     <= '0;
            // A zero-length grant is acknowledged but opens no HS window.
            if (w_len != '0) begin
              r_hs_en <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= ST_LEAD;
            end
          end
        end

        ST_LEAD: begin
          if (!I_init_done) begin
            r_hs_en <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_GAP;
          end else if (r_cnt == LEAD_LAST) begin
            r_vid_rd <= (r_sel == SEL_VID);
            r_cmd_rd <= (r_sel == SEL_CMD);
            r_rem    <= r_rem - LEN_W'(1);
            r_state  <= ST_BURST;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_BURST: begin
          if (!I_init_done) begin
            r_vid_rd <= 1'b0;
            r_cmd_rd <= 1'b0;
            r_hs_en  <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_GAP;
          end else if (r_rem != '0) begin
            // r_rem counts strobes still to issue after the current one.
            r_rem <= r_rem - LEN_W'(1);
          end else begin
            r_vid_rd <= 1'b0;
            r_cmd_rd <= 1'b0;
            r_cnt    <= '0;
            if (HS_TRAIL_PAD == 0) begin
              r_hs_en <= 1'b0;
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_TAIL;
            end
          end
        end

        ST_TAIL: begin
          if (!I_init_done || (r_cnt == TAIL_LAST)) begin
            r_hs_en <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_vid_rd <= 1'b0;
          r_cmd_rd <= 1'b0;
          r_hs_en  <= 1'b0;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign O_vid_ack   = r_vid_ack;
  assign O_cmd_ack   = r_cmd_ack;
  assign O_vid_rd    = r_vid_rd;
  assign O_cmd_rd    = r_cmd_rd;
  assign O_sel       = r_sel;
  assign O_hs_en     = r_hs_en;
  assign O_busy      = r_busy;
  assign O_dbg_state = r_state;

endmodule

// File: tb/tb_mipi_hs_burst_sched.sv
// Bench for mipi_hs_burst_sched: a transaction model predicts grant order and
// burst timing; a negedge monitor pops expectations on every ack and checks them.
module tb_mipi_hs_burst_sched;

  localparam int LEN_W = 16;
  localparam int OFS   = 0;
  localparam int PAD   = 72;
  localparam int GAP   = 96;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             init_done;
  logic             vid_req;
  logic [LEN_W-1:0] vid_len;
  logic             cmd_req;
  logic [LEN_W-1:0] cmd_len;
  logic             o_vid_ack, o_vid_rd, o_cmd_ack, o_cmd_rd;
  logic             o_sel, o_hs_en, o_busy;
  logic [2:0]       o_dbg_state;

  mipi_hs_burst_sched #(
    .LEN_W(LEN_W), .HS_RD_OFS(OFS), .HS_TRAIL_PAD(PAD), .MIN_LP_GAP(GAP)
  ) dut (
    .I_lcd_clk   (clk),
    .I_rst_n     (rst_n),
    .I_init_done (init_done),
    .I_vid_req   (vid_req),
    .I_vid_len   (vid_len),
    .O_vid_ack   (o_vid_ack),
    .O_vid_rd    (o_vid_rd),
    .I_cmd_req   (cmd_req),
    .I_cmd_len   (cmd_len),
    .O_cmd_ack   (o_cmd_ack),
    .O_cmd_rd    (o_cmd_rd),
    .O_sel       (o_sel),
    .O_hs_en     (o_hs_en),
    .O_busy      (o_busy),
    .O_dbg_state (o_dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic sel;
    int   len;
    int   rd_n;
    int   hs_n;
  } exp_t;

  exp_t exp_q[$];
  int   ack_hist[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acks = 0;
  int   last_ack = -1;
  int   last_fall = -1;
  logic mdl_ptr = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic sel, input int len);
    exp_t e;
    e.sel  = sel;
    e.len  = len;
    e.rd_n = len;
    e.hs_n = (len == 0) ? 0 : 1 + OFS + len + PAD;
    exp_q.push_back(e);
  endtask

  task automatic push_abort(input logic sel, input int len, input int k);
    exp_t e;
    e.sel  = sel;
    e.len  = len;
    e.rd_n = k;
    e.hs_n = 1 + OFS + k;
    exp_q.push_back(e);
  endtask

  // Reference arbitration: tie goes to the pointer, pointer moves past each grant.
  task automatic issue(input bit v, input int vl, input bit c, input int cl);
    if (v && c) begin
      if (mdl_ptr == 1'b0) begin push(1'b0, vl); push(1'b1, cl); end
      else                 begin push(1'b1, cl); push(1'b0, vl); end
    end else if (v) begin
      push(1'b0, vl);
      mdl_ptr = 1'b1;
    end else if (c) begin
      push(1'b1, cl);
      mdl_ptr = 1'b0;
    end
    if (v) begin vid_len = vl[LEN_W-1:0]; vid_req = 1'b1; end
    if (c) begin cmd_len = cl[LEN_W-1:0]; cmd_req = 1'b1; end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_acks();
    int n = 0;
    while ((vid_req || cmd_req) && n < 3000) begin
      @(negedge clk);
      n++;
      if (o_vid_ack) vid_req = 1'b0;
      if (o_cmd_ack) cmd_req = 1'b0;
    end
    chk("requests_acked", int'({vid_req, cmd_req}), 0);
    vid_req = 1'b0;
    cmd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", int'(o_busy), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t cur;
    bit   have_cur = 0;
    logic prev_hs = 1'b0;
    int   ack_c = 0, rd_n = 0, rd_first = -1, rd_last = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_cur  = 0;
        prev_hs   = 1'b0;
        last_fall = -1;
      end else begin
        if (o_vid_ack || o_cmd_ack) begin
          n_acks++;
          ack_hist.push_back(cyc);
          last_ack = cyc;
          chk("ack_onehot", int'(o_vid_ack ^ o_cmd_ack), 1);
          if (exp_q.size() == 0) begin
            chk("ack_was_expected", exp_q.size(), 1);
          end else begin
            cur = exp_q.pop_front();
            chk("ack_channel", int'(o_cmd_ack), int'(cur.sel));
            chk("sel_at_ack", int'(o_sel), int'(cur.sel));
            chk("hs_en_at_ack", int'(o_hs_en), int'(cur.len != 0));
            chk("busy_at_ack", int'(o_busy), int'(cur.len != 0));
            if (last_fall >= 0) begin
              n_cmp++;
              if (cyc - last_fall < GAP + 1) begin
                n_err++;
                $display("FAIL lp_gap: got %0d cycles from hs_en fall to ack, required >= %0d",
                         cyc - last_fall, GAP + 1);
              end
            end
            if (cur.len != 0) begin
              have_cur = 1;
              ack_c    = cyc;
              rd_n     = 0;
              rd_first = -1;
              rd_last  = -1;
            end
          end
        end
        if (o_vid_rd || o_cmd_rd) begin
          chk("rd_inside_burst", int'(have_cur), 1);
          chk("rd_inside_hs", int'(o_hs_en), 1);
          if (have_cur) begin
            chk("rd_channel", int'({o_cmd_rd, o_vid_rd}), cur.sel ? 2 : 1);
            chk("sel_held", int'(o_sel), int'(cur.sel));
            if (rd_n > 0) chk("rd_contiguous", cyc, rd_last + 1);
            if (rd_first < 0) rd_first = cyc;
            rd_last = cyc;
            rd_n++;
          end
        end
        if (prev_hs && !o_hs_en) begin
          if (have_cur) begin
            chk("hs_en_high_time", cyc - ack_c, cur.hs_n);
            chk("rd_count", rd_n, cur.rd_n);
            chk("rd_first_offset", rd_first - ack_c, 1 + OFS);
            have_cur = 0;
          end
          last_fall = cyc;
        end
        prev_hs = o_hs_en;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int   k, t0, rd_seen, n;
    logic hs_seen;
    rst_n     = 1'b0;
    init_done = 1'b1;
    vid_req   = 1'b0;
    cmd_req   = 1'b0;
    vid_len   = '0;
    cmd_len   = '0;
    #23;
    chk("rst_hs_en", int'(o_hs_en), 0);
    chk("rst_acks", int'({o_vid_ack, o_cmd_ack}), 0);
    chk("rst_rds", int'({o_vid_rd, o_cmd_rd}), 0);
    chk("rst_sel", int'(o_sel), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_state", int'(o_dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Video alone, len 10: window, strobes and the following gap.
    issue(1, 10, 0, 0);
    wait_acks();
    wait_idle();

    // Zero-length command: ack only, no window, scheduler stays idle.
    issue(0, 0, 1, 0);
    hs_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_cmd_ack) cmd_req = 1'b0;
      hs_seen = hs_seen | o_hs_en | o_busy;
    end
    chk("len0_no_window", int'(hs_seen), 0);
    chk("len0_ack_count", n_acks, 2);

    // Tie with pointer on video, then command waits out the gap, then video again.
    issue(1, 6, 1, 8);
    wait_acks();
    chk("rr_cmd_after_gap", last_ack - last_fall, GAP + 1);
    issue(1, 5, 0, 0);
    wait_acks();
    chk("rr_vid_after_gap", last_ack - last_fall, GAP + 1);
    wait_idle();

    // Init low holds off pending grants; grant follows init rising by one cycle.
    init_done = 1'b0;
    @(negedge clk);
    k = n_acks;
    issue(1, 3, 1, 2);
    hs_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      hs_seen = hs_seen | o_hs_en;
    end
    chk("init_low_no_ack", n_acks - k, 0);
    chk("init_low_no_hs", int'(hs_seen), 0);
    init_done = 1'b1;
    t0 = cyc;
    wait_acks();
    chk("init_rise_grant", (ack_hist.size() > k) ? ack_hist[k] : -1, t0 + 1);
    wait_idle();

    // Init drops after 5 strobes of a 20-cycle burst; pending command survives.
    push_abort(1'b0, 20, 5);
    mdl_ptr = 1'b1;
    vid_len = 16'd20;
    vid_req = 1'b1;
    rd_seen = 0;
    n = 0;
    while (rd_seen < 5 && n < 500) begin
      @(negedge clk);
      n++;
      if (o_vid_ack) begin
        vid_req = 1'b0;
        push(1'b1, 7);
        mdl_ptr = 1'b0;
        cmd_len = 16'd7;
        cmd_req = 1'b1;
      end
      if (o_vid_rd) rd_seen++;
    end
    chk("abort_rd_reached", rd_seen, 5);
    init_done = 1'b0;
    @(negedge clk);
    chk("abort_rd_low", int'({o_vid_rd, o_cmd_rd}), 0);
    chk("abort_hs_low", int'(o_hs_en), 0);
    repeat (9) @(negedge clk);
    init_done = 1'b1;
    wait_acks();
    chk("abort_then_gap", last_ack - last_fall, GAP + 1);
    wait_idle();

    // Asynchronous reset in the trail of a command burst.
    issue(0, 0, 1, 4);
    wait_acks();
    repeat (20) @(negedge clk);
    chk("tail_hs_before_reset", int'(o_hs_en), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hs_en", int'(o_hs_en), 0);
    chk("arst_sel", int'(o_sel), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_rds_acks", int'({o_vid_rd, o_cmd_rd, o_vid_ack, o_cmd_ack}), 0);
    chk("arst_state", int'(o_dbg_state), 0);
    mdl_ptr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1, 2, 1, 3);
    wait_acks();
    wait_idle();

    // Randomized mix of single and tied requests, including zero lengths.
    for (int it = 0; it < 12; it++) begin
      int  mode, vl, cl;
      mode = $urandom_range(1, 3);
      vl   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
      cl   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
      issue(mode[0], vl, mode[1], cl);
      wait_acks();
      wait_idle();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
